// File: rtl/imem_pkg.sv
// imem_pkg: shared states and sizing constants for the instruction-memory loader.
package imem_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CSUM} state_t;
  localparam int IMEM_BYTES = 32;
  localparam int INSTR_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES = INSTR_W / LANE_W;
  localparam int LANE_IDX_W = $clog2(LANES);
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs bytes little-endian into a 32-bit word, pulsing word_ready on the last lane.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [LANE_W-1:0]  data,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);
  logic [LANE_IDX_W-1:0] byte_idx;
  assign word_ready = load && byte_idx == LANE_IDX_W'(LANES - 1);
  // byte_idx wraps to 0 on the last lane, so the next word starts cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      word <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (load) begin
      word[{byte_idx, 3'b000} +: LANE_W] <= data;
      byte_idx <= byte_idx + 1'b1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into instruction memory as 32-bit words and holds the core until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_hold
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_ST = DONE;
`endif
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(DEPTH_WORDS);
  state_t state, state_n;
  logic [CNT_W-1:0] target, word_idx;
  logic [INSTR_W-1:0] word, last_data;
  logic [31:0] cur_addr, last_addr;
  logic take_start, aborting, xfer, load, word_ready, last_word;
  assign busy = state == RECV || state == WRITE;
  assign done = state == DONE;
  assign core_hold = reset || busy || !done;
  assign take_start = start && (state == IDLE || state == DONE);
  assign aborting = abort && busy;
  assign byte_ready = (state == RECV || state == CSUM) && !abort;
  assign xfer = byte_valid && byte_ready;
  assign load = xfer && state == RECV;
  assign last_word = word_idx + CNT_W'(1) == target;
  assign cur_addr = {{(30 - CNT_W){1'b0}}, word_idx, 2'b00};
  assign wr_en = state == WRITE && !abort;
  // Outputs hold the last written word between strobes
  assign wr_addr = wr_en ? cur_addr : last_addr;
  assign wr_data = wr_en ? word : last_data;
  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (take_start || aborting),
    .load       (load),
    .data       (byte_data),
    .word       (word),
    .word_ready (word_ready)
  );
  always_comb begin
    state_n = state;
    if (aborting) state_n = IDLE;
    else if (take_start) state_n = num_words == '0 ? END_ST : RECV;
    else if (state == RECV && word_ready) state_n = WRITE;
    else if (state == WRITE) state_n = last_word ? END_ST : RECV;
    else if (state == CSUM && xfer) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      target <= '0;
      word_idx <= '0;
      err <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (take_start) begin
        target <= num_words > DEPTH ? DEPTH : num_words;
        err <= num_words > DEPTH;
        word_idx <= '0;
      end
      if (aborting) err <= 1'b1;
      if (wr_en) begin
        last_addr <= cur_addr;
        last_data <= word;
        word_idx <= word_idx + 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CSUM && xfer && byte_data != csum) err <= 1'b1;
`endif
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || take_start) csum <= '0;
    else if (load) csum <= csum ^ byte_data;
  end
`endif
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian instruction words.
- Issues one word write per instruction to the instruction-memory write port, at byte addresses 0, 4, 8, ...
- Holds the core in reset until the program is fully loaded.
- Sits between the host/debug byte link and the instruction memory.

Parameters:
- DEPTH_WORDS, 8, number of 32-bit instruction slots in memory (32 bytes).
- CNT_W, 4, width of the word-count input and counters; must satisfy 2**CNT_W > DEPTH_WORDS.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- start  input  1  begin a load; sampled only in IDLE or DONE
- num_words  input  CNT_W  number of words to load; sampled with start
- abort  input  1  cancel an in-progress load
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte; first byte of a word is instruction bits [7:0]
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  one-cycle instruction-memory word write strobe
- wr_addr  output  32  byte address of the word write (word_idx*4)
- wr_data  output  32  assembled instruction word
- busy  output  1  high in RECV or WRITE
- done  output  1  high in DONE until the next start
- err  output  1  sticky error flag, cleared by start or reset
- core_hold  output  1  holds the core in reset: reset OR busy OR (not done)

Behaviour:
- Reset values: state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0; core_hold=1. Internal byte_idx=0, word_idx=0, assembly register=0.
- State IDLE, entered from reset:
  - start=1 latches num_words into target, clears err, clears word_idx and byte_idx, then goes to RECV.
  - If num_words=0: go directly to DONE; no writes occur.
  - If num_words>DEPTH_WORDS: clamp target to DEPTH_WORDS and set err=1.
- State RECV:
  - byte_ready=1; a byte transfers only on a cycle where byte_valid&&byte_ready.
  - Byte k (k=0..3) is stored into assembly bits [8k+7:8k], then byte_idx increments.
  - The transfer of byte 3 moves to WRITE; byte_ready is 0 in WRITE, so no fifth byte is accepted.
  - byte_valid may drop between bytes; partial assembly is held indefinitely.
- State WRITE, exactly one cycle:
  - wr_en=1, wr_addr={word_idx,2'b00} zero-extended to 32 bits, wr_data=assembled word.
  - Then word_idx increments and byte_idx returns to 0.
  - If word_idx+1==target, go to DONE; otherwise go to RECV.
- Latency: the last byte's handshake edge is followed by wr_en high in the next cycle.
- State DONE: done=1, core_hold=0. start=1 re-enters the load exactly as from IDLE, which supports reloading.
- abort in RECV or WRITE:
  - Go to IDLE next cycle and set err=1.
  - An abort in WRITE suppresses that cycle's wr_en; abort has priority over write.
  - Memory keeps words already written.
- Simultaneous events:
  - reset dominates everything.
  - abort dominates byte transfer and write.
  - start is ignored while busy.
- Reset mid-load: all state returns to reset values the next cycle; any partial word is discarded and never written.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined: after the final word, a state CSUM is inserted with byte_ready=1.
  - One trailing byte is accepted and compared to the XOR of all payload bytes.
  - On mismatch, err=1.
  - DONE is entered in either case.
  - num_words=0 still expects a checksum byte, which must equal 8'h00.
- When undefined: no CSUM state; DONE follows the last WRITE directly.

Decomposition:
- Shared package imem_pkg holds:
  - state enum (IDLE, RECV, WRITE, DONE, CSUM)
  - IMEM_BYTES=32
  - INSTR_W=32
  - byte-lane constants
- One natural sub-module, imem_word_assembler: byte_idx counter plus 32-bit shift/lane register, with a word_ready pulse output.
- The FSM, counters and write port stay in imem_loader.

Test Plan:
- Basic load: reset, then start with num_words=2, bytes 33 03 94 00 b3 03 39 41 sent back-to-back. Expect wr_en at addr 0x0 with data 0x00940333, then addr 0x4 with 0x413903b3. Then done=1, core_hold=0, err=0.
- Backpressure: same stream with byte_valid low for 3 cycles between every byte. Expect identical writes, exactly one wr_en per word, and byte_ready never high in WRITE.
- Boundaries:
  - num_words=0: done one cycle after start, no wr_en.
  - num_words=9: err=1, exactly 8 writes at addresses 0x0..0x1C, then done.
- Abort/reset mid-word: after 2 bytes of word 1, assert abort. Expect IDLE, err=1, no write of the partial word. Repeat with reset instead: all outputs return to reset values and core_hold=1.
- Reload from DONE: start with num_words=1 and bytes 33 0a 7b 01. Expect a write at 0x0 with data 0x017b0a33, err cleared, done re-asserted.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): 1 word 33 03 94 00 followed by checksum byte a4 gives err=0. Sending checksum byte a5 instead gives err=1, with done still asserted.
